// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and the CPU-port state type.
package vga_pkg;
    localparam int HLINES       = 640;
    localparam int VLINES       = 480;
    localparam int HMAX         = 800;
    localparam int VMAX         = 525;
    localparam int LINE_WORDS   = 80;
    localparam int PIX_PER_WORD = 4;
    typedef enum logic {CPU_IDLE, CPU_RD_WAIT} cpu_state_e;
endpackage

// File: rtl/vga_fb_arbiter_shifter.sv
// pixel_shifter: holds one fetched framebuffer word and emits it nibble by nibble, each nibble for 2 cycles.
// Ports: clk/rst_n (async active-low), load_i loads din_i and restarts the 2:1 cadence, pix_o = current nibble.
module pixel_shifter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [3:0]        pix_o
);
    logic [DATA_W-1:0] sh_q;
    logic              tog_q;
    // tog_q marks the second cycle of a doubled pixel; the shift happens at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            tog_q <= 1'b0;
        end else if (load_i) begin
            sh_q  <= din_i;
            tog_q <= 1'b0;
        end else begin
            sh_q  <= tog_q ? sh_q >> 4 : sh_q;
            tog_q <= ~tog_q;
        end
    end
    assign pix_o = sh_q[3:0];
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between VGA scan-out and a CPU req/ack port.
// Ports: pixel_clk/rst_n (async active-low); hcount/vcount from the timing controller;
// cpu_req/we/addr/wdata in, cpu_ack/cpu_rdata out; mem_addr/we/wdata out, mem_rdata in (1-cycle latency);
// pix_out/pix_valid palette index stream, 2 cycles behind hcount.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 80
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        pix_out,
    output logic              pix_valid
);
    cpu_state_e        state_q, state_d;
    logic              rd_ack_q, disp_q;
    logic [1:0]        act_q;
    logic [DATA_W-1:0] rdata_q, wdata_q;
    logic              active, disp, grant, wr_go, rd_go;
    logic [ADDR_W-1:0] vline, disp_addr;

    assign active    = hcount < 11'(HLINES) && vcount < 11'(VLINES);
    // One fetch per 8-pixel group; hcount/8 < LINE_WORDS is the same test as hcount < 640.
    assign disp      = rst_n && hcount[10:3] < 8'(LINE_WORDS) && vcount < 11'(VLINES) && hcount[2:0] == 3'd0;
    assign vline     = ADDR_W'(vcount[10:1]);
    assign disp_addr = (vline << 6) + (vline << 4) + ADDR_W'(hcount[10:3]);
    // The ack cycle of a read is excluded so a still-held request is not serviced twice.
    assign grant     = rst_n && cpu_req && !disp && state_q == CPU_IDLE && !rd_ack_q;
    assign wr_go     = grant && cpu_we;
    assign rd_go     = grant && !cpu_we;
    assign mem_addr  = disp ? disp_addr : grant ? cpu_addr : '0;
    assign mem_we    = wr_go;
    assign mem_wdata = wr_go ? cpu_wdata : wdata_q;
    assign cpu_ack   = wr_go || rd_ack_q;
    assign cpu_rdata = rdata_q;
    assign pix_valid = act_q[1];
    assign state_d   = rd_go ? CPU_RD_WAIT : CPU_IDLE;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CPU_IDLE;
            rd_ack_q <= 1'b0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            disp_q   <= 1'b0;
            act_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            rd_ack_q <= state_q == CPU_RD_WAIT;
            rdata_q  <= state_q == CPU_RD_WAIT ? mem_rdata : rdata_q;
            wdata_q  <= mem_wdata;
            disp_q   <= disp;
            act_q    <= {act_q[0], active};
        end
    end

    // disp_q is high in phase 1, when the display word is on mem_rdata.
    pixel_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk    (pixel_clk),
        .rst_n  (rst_n),
        .load_i (disp_q),
        .din_i  (mem_rdata),
        .pix_o  (pix_out)
    );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench with a behavioural framebuffer RAM.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, vcount;
    logic        cpu_req, cpu_we, cpu_ack, mem_we, pix_valid;
    logic [14:0] cpu_addr, mem_addr;
    logic [15:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic [3:0]  pix_out;
    logic [15:0] ram [0:32767];
    logic [15:0] refm [0:99];
    logic [3:0]  expix [0:7];
    int          passed = 0, total = 0;
    logic        req_on, rwe, done;
    int          ridx, waitc;
    logic [15:0] rdat;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vga_fb_arbiter dut (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_out   (pix_out),
        .pix_valid (pix_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        hcount = 11'd700; vcount = 11'd500;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        settle;
        chk("pre_ack", cpu_ack, 1);
        adv;
        cpu_req = 1'b0;
    endtask

    initial begin
        expix[0] = 4'd1; expix[1] = 4'd1; expix[2] = 4'd2; expix[3] = 4'd2;
        expix[4] = 4'd3; expix[5] = 4'd3; expix[6] = 4'd4; expix[7] = 4'd4;
        rst_n = 1'b0; hcount = 11'd700; vcount = 11'd500;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 16'h1111;
        repeat (3) @(posedge clk);
        #1;
        settle;
        chk("rst_ack", cpu_ack, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_pv", pix_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata", cpu_rdata, 0);
        adv;
        rst_n = 1'b1;
        settle;
        chk("first_ack", cpu_ack, 1);
        chk("first_we", mem_we, 1);
        chk("first_addr", mem_addr, 5);
        chk("first_wdata", mem_wdata, 16'h1111);
        adv;
        cpu_we = 1'b0;
        settle;
        chk("rd_grant_addr", mem_addr, 5);
        chk("rd_grant_ack", cpu_ack, 0);
        adv;
        rst_n = 1'b0;
        settle;
        chk("rstmid_ack", cpu_ack, 0);
        adv;
        rst_n = 1'b1;
        settle;
        chk("reissue_addr", mem_addr, 5);
        chk("reissue_ack0", cpu_ack, 0);
        adv;
        settle;
        chk("reissue_ack1", cpu_ack, 0);
        adv;
        settle;
        chk("reissue_ack2", cpu_ack, 1);
        chk("reissue_rdata", cpu_rdata, 16'h1111);
        adv;
        cpu_req = 1'b0;
        wr(15'd0, 16'h4321);
        wr(15'd1, 16'h8765);
        wr(15'h1234, 16'hBEEF);
        vcount = 11'd0;
        for (int h = 0; h < 646; h++) begin
            hcount = 11'(h);
            settle;
            if (h >= 2 && h <= 9) begin
                chk("pix_out", pix_out, expix[h-2]);
                chk("pix_valid_on", pix_valid, 1);
            end
            if (h == 1 || h == 642) chk("pix_valid_off", pix_valid, 0);
            if (h == 641) chk("pix_valid_last", pix_valid, 1);
            adv;
        end
        hcount = 11'd5;
        settle;
        adv;
        hcount = 11'd6;
        settle;
        adv;
        hcount = 11'd7; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        settle;
        chk("rd7_addr", mem_addr, 16'h1234);
        chk("rd7_we", mem_we, 0);
        chk("rd7_ack", cpu_ack, 0);
        adv;
        hcount = 11'd8;
        settle;
        chk("rd8_disp_addr", mem_addr, 1);
        chk("rd8_we", mem_we, 0);
        chk("rd8_ack", cpu_ack, 0);
        adv;
        hcount = 11'd9;
        settle;
        chk("rd9_ack", cpu_ack, 1);
        chk("rd9_rdata", cpu_rdata, 16'hBEEF);
        adv;
        cpu_req = 1'b0; hcount = 11'd10;
        settle;
        chk("rd10_pix", pix_out, 5);
        chk("rd10_pv", pix_valid, 1);
        adv;
        vcount = 11'd3; hcount = 11'd16;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 16'hA5A5;
        settle;
        chk("wr16_addr", mem_addr, 82);
        chk("wr16_we", mem_we, 0);
        chk("wr16_ack", cpu_ack, 0);
        adv;
        hcount = 11'd17;
        settle;
        chk("wr17_we", mem_we, 1);
        chk("wr17_addr", mem_addr, 16'h0100);
        chk("wr17_ack", cpu_ack, 1);
        chk("wr17_wdata", mem_wdata, 16'hA5A5);
        adv;
        cpu_req = 1'b0;
        chk("wr_ram", ram[15'h0100], 16'hA5A5);
        vcount = 11'd490; cpu_req = 1'b1; cpu_we = 1'b1;
        for (int i = 0; i < 100; i++) begin
            hcount = 11'(i);
            cpu_addr = 15'h3000 + 15'(i);
            cpu_wdata = 16'(i * 613 + 7);
            refm[i] = cpu_wdata;
            settle;
            chk("b2b_ack", cpu_ack, 1);
            adv;
        end
        cpu_req = 1'b0;
        for (int i = 0; i < 100; i++) chk("b2b_ram", ram[15'h3000 + 15'(i)], refm[i]);
        req_on = 1'b0; rwe = 1'b0; ridx = 0; rdat = '0; waitc = 0;
        for (int v = 476; v < 484; v++) begin
            for (int h = 0; h < 800; h++) begin
                if (!req_on && $urandom_range(0, 2) != 0) begin
                    req_on = 1'b1;
                    rwe = 1'($urandom_range(0, 1));
                    ridx = int'($urandom_range(0, 99));
                    rdat = 16'($urandom);
                    waitc = 0;
                end
                hcount = 11'(h); vcount = 11'(v);
                cpu_req = req_on; cpu_we = rwe; cpu_addr = 15'h3000 + 15'(ridx); cpu_wdata = rdat;
                done = 1'b0;
                settle;
                if (h < 640 && v < 480 && h % 8 == 0) begin
                    chk("slot_we", mem_we, 0);
                    chk("slot_addr", mem_addr, (v / 2) * 80 + h / 8);
                end
                if (req_on) begin
                    if (cpu_ack) begin
                        if (rwe) refm[ridx] = rdat;
                        else chk("rnd_rdata", cpu_rdata, refm[ridx]);
                        done = 1'b1;
                    end else begin
                        waitc++;
                        if (waitc > 4) begin
                            chk("rnd_wait", waitc, 4);
                            done = 1'b1;
                        end
                    end
                end
                adv;
                if (done) req_on = 1'b0;
            end
        end
        cpu_req = 1'b0;
        adv;
        adv;
        for (int i = 0; i < 100; i++) chk("rnd_ram", ram[15'h3000 + 15'(i)], refm[i]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
